uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_tx` serializer among `NUM_REQ` byte-stream requesters, such as the CPU console, debug dump and trace. It accepts bytes over per-requester valid/ready, issues single-cycle `tx_start` pulses to `uart_tx` and waits for `tx_end` before issuing the next byte. A grant is held for the whole packet, up to a byte flagged `req_last`, so streams never interleave mid-packet. It sits between the requester bus and `uart_tx` in the simple ARM I/O subsystem.

---
 rtl/uart_pkg.sv | 7 +
 rtl/rr_pick.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 93 +++++++++
 tb/tb_uart_tx_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART subsystem
package uart_pkg;
  localparam int BYTE_DATA_W = 8;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
  typedef enum logic [1:0] {ARB_IDLE, ARB_START, ARB_WAIT, ARB_HOLD} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker scanning upward from ptr+1 with wrap
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);
  int best;
  // the active request with the smallest wrapped distance from ptr+1 wins
  always_comb begin
    best = NUM_REQ;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req[i] && (i + NUM_REQ - 1 - int'(ptr)) % NUM_REQ < best) begin
        best = (i + NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
        idx = IW'(i);
      end
    gnt = (best < NUM_REQ) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << idx : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one uart_tx among byte-stream requesters
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int LOCK_TIMEOUT = 1023,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*BYTE_DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [BYTE_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  input  logic                           tx_end,
  output logic [IW-1:0]                  grant_id,
  output logic                           active
);
  arb_state_t state, state_nx;
  logic [IW-1:0] ptr, take_idx, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [9:0] lock_cnt;
  logic last_q, take, timeout, cap_last;
  logic [BYTE_DATA_W-1:0] cap_data;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );

  assign timeout = (LOCK_TIMEOUT != 0) && (lock_cnt == 10'(LOCK_TIMEOUT));
  assign tx_start = state == ARB_START;
  assign active = state != ARB_IDLE;

  // next state, accept pulse and selection of the byte to capture; accept beats timeout in HOLD
  always_comb begin
    state_nx = state;
    req_ready = '0;
    take = DISABLE;
    take_idx = grant_id;
    cap_data = '0;
    cap_last = 1'b0;
    if (!reset)
      case (state)
        ARB_IDLE:
          if (!tx_busy && |req_valid) begin
            req_ready = pick_gnt;
            take = ENABLE;
            take_idx = pick_idx;
            state_nx = ARB_START;
          end
        ARB_START: state_nx = ARB_WAIT;
        ARB_WAIT: state_nx = tx_end ? (last_q ? ARB_IDLE : ARB_HOLD) : ARB_WAIT;
        ARB_HOLD:
          if (req_valid[grant_id] && !tx_busy) begin
            req_ready[grant_id] = 1'b1;
            take = ENABLE;
            state_nx = ARB_START;
          end else if (timeout) state_nx = ARB_IDLE;
        default: state_nx = ARB_IDLE;
      endcase
    for (int i = 0; i < NUM_REQ; i++)
      if (take_idx == IW'(i)) begin
        cap_data = req_data[BYTE_DATA_W*i +: BYTE_DATA_W];
        cap_last = req_last[i];
      end
  end

  // state, captured byte, grant and round-robin pointer; lock counter saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      tx_data <= '0;
      last_q <= 1'b0;
      grant_id <= '0;
      lock_cnt <= '0;
      ptr <= IW'(NUM_REQ - 1);
    end else begin
      state <= state_nx;
      if (take) begin
        tx_data <= cap_data;
        last_q <= cap_last;
        grant_id <= take_idx;
      end
      if (state == ARB_WAIT) lock_cnt <= '0;
      else if (state == ARB_HOLD && !take && lock_cnt != '1) lock_cnt <= lock_cnt + 1'b1;
      if (state != ARB_IDLE && state_nx == ARB_IDLE) ptr <= grant_id;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenario bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic clk, reset, tx_busy, tx_end, tx_start, active;
  logic [3:0] req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  int checks, errors;

  uart_tx_arbiter #(.NUM_REQ(4), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_end(tx_end),
    .grant_id(grant_id), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    tx_busy = 1'b0;
    tx_end = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready(output logic [3:0] seen, output int cyc);
    cyc = 0;
    #1;
    while (req_ready === 4'b0 && cyc < 40) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    seen = req_ready;
  endtask

  task automatic finish_byte(input logic [7:0] d, input logic [1:0] gid, input string nm);
    #1;
    checks++;
    if (tx_start !== 1'b1 || tx_data !== d || grant_id !== gid) begin
      errors++;
      $display("FAIL %s start: tx_start=%b tx_data=%h grant_id=%0d, want 1 %h %0d", nm, tx_start, tx_data, grant_id, d, gid);
    end
    tx_busy = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (tx_start !== 1'b0 || req_ready !== 4'b0 || active !== 1'b1) begin
      errors++;
      $display("FAIL %s wait: tx_start=%b req_ready=%b active=%b, want 0 0000 1", nm, tx_start, req_ready, active);
    end
    @(negedge clk);
    tx_end = 1'b1;
    tx_busy = 1'b0;
    @(negedge clk);
    tx_end = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || req_ready !== 4'b0 || grant_id !== 2'd0 || active !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: start=%b data=%h ready=%b gid=%0d active=%b, want 0 00 0000 0 0", tx_start, tx_data, req_ready, grant_id, active);
    end
  endtask

  task automatic test_single();
    logic [3:0] seen;
    int cyc;
    @(negedge clk);
    req_valid = 4'b0001;
    req_data[7:0] = 8'hA5;
    req_last = 4'b0001;
    wait_ready(seen, cyc);
    checks++;
    if (seen !== 4'b0001 || cyc != 0) begin
      errors++;
      $display("FAIL single_accept: ready=%b after %0d cycles, want 0001 after 0", seen, cyc);
    end
    @(negedge clk);
    req_valid = '0;
    finish_byte(8'hA5, 2'd0, "single");
    #1;
    checks++;
    if (active !== 1'b0 || tx_data !== 8'hA5 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL single_idle: active=%b data=%h ready=%b, want 0 a5 0000", active, tx_data, req_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seen;
    int cyc;
    int order[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    req_valid = 4'b1111;
    req_last = 4'b1111;
    req_data = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      wait_ready(seen, cyc);
      checks++;
      if (seen !== 4'(1 << order[k]) || cyc != 0) begin
        errors++;
        $display("FAIL rr_grant_%0d: ready=%b after %0d cycles, want %b after 0", k, seen, cyc, 4'(1 << order[k]));
      end
      @(negedge clk);
      finish_byte(8'h10 + 8'(order[k]), 2'(order[k]), "rr");
    end
    req_valid = '0;
  endtask

  task automatic test_packet();
    logic [3:0] seen;
    int cyc;
    logic [7:0] pkt[3] = '{8'h11, 8'h22, 8'h33};
    apply_reset();
    req_valid = 4'b0110;
    req_last = 4'b0100;
    req_data = {8'h00, 8'h2B, pkt[0], 8'h00};
    for (int k = 0; k < 3; k++) begin
      wait_ready(seen, cyc);
      checks++;
      if (seen !== 4'b0010 || cyc != 0) begin
        errors++;
        $display("FAIL packet_byte_%0d: ready=%b after %0d cycles, want 0010 after 0", k, seen, cyc);
      end
      @(negedge clk);
      if (k < 2) begin
        req_data[15:8] = pkt[k+1];
        req_last[1] = (k == 1);
      end else req_valid[1] = 1'b0;
      finish_byte(pkt[k], 2'd1, "packet");
    end
    wait_ready(seen, cyc);
    checks++;
    if (seen !== 4'b0100 || cyc != 0) begin
      errors++;
      $display("FAIL packet_next_owner: ready=%b after %0d cycles, want 0100 after 0", seen, cyc);
    end
    @(negedge clk);
    req_valid = '0;
    finish_byte(8'h2B, 2'd2, "packet_r2");
  endtask

  task automatic test_timeout();
    logic [3:0] seen;
    int cyc, n;
    logic bad;
    apply_reset();
    req_valid = 4'b1000;
    req_last = 4'b0000;
    req_data = {8'h3C, 24'h0};
    wait_ready(seen, cyc);
    checks++;
    if (seen !== 4'b1000) begin
      errors++;
      $display("FAIL timeout_first: ready=%b, want 1000", seen);
    end
    @(negedge clk);
    req_valid = 4'b0001;
    req_last = 4'b0001;
    req_data[7:0] = 8'h0F;
    finish_byte(8'h3C, 2'd3, "timeout");
    n = 0;
    bad = 1'b0;
    #1;
    while (active === 1'b1 && n < 40) begin
      if (req_ready !== 4'b0) bad = 1'b1;
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 17 || bad) begin
      errors++;
      $display("FAIL timeout_hold: held %0d cycles (stray ready %b), want 17 (0)", n, bad);
    end
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL timeout_regrant: ready=%b, want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0010;
    req_last = 4'b0000;
    req_data[15:8] = 8'h5A;
    finish_byte(8'h0F, 2'd0, "timeout_r0");
    wait_ready(seen, cyc);
    checks++;
    if (seen !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_race_first: ready=%b, want 0010", seen);
    end
    @(negedge clk);
    req_valid = '0;
    finish_byte(8'h5A, 2'd1, "race");
    repeat (16) @(negedge clk);
    req_valid = 4'b0010;
    req_last = 4'b0010;
    req_data[15:8] = 8'h5B;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_race_accept: ready=%b, want 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    finish_byte(8'h5B, 2'd1, "race2");
    #1;
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL race_end: active=%b, want 0", active);
    end
  endtask

  task automatic test_busy();
    logic bad;
    apply_reset();
    tx_busy = 1'b1;
    req_valid = 4'b0010;
    req_last = 4'b0010;
    req_data[15:8] = 8'h42;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (req_ready !== 4'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL busy_block: ready seen while busy, want none");
    end
    tx_busy = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL busy_release: ready=%b, want 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    finish_byte(8'h42, 2'd1, "busy");
  endtask

  task automatic test_reset_mid();
    logic [3:0] seen;
    int cyc;
    apply_reset();
    req_valid = 4'b0100;
    req_last = 4'b0100;
    req_data[23:16] = 8'h77;
    wait_ready(seen, cyc);
    @(negedge clk);
    tx_busy = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || req_ready !== 4'b0 || grant_id !== 2'd0 || active !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: start=%b data=%h ready=%b gid=%0d active=%b, want 0 00 0000 0 0", tx_start, tx_data, req_ready, grant_id, active);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: ready=%b, want 0000", req_ready);
    end
    tx_busy = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL reset_mid_reaccept: ready=%b, want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    finish_byte(8'h77, 2'd2, "reset_mid");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    tx_busy = 1'b0;
    tx_end = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_packet();
    test_timeout();
    test_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
